// File: rtl/mux_onehot_pkg.sv
// Shared helpers for the round-robin one-hot mux stage:
// index width, one-hot encode and rotate-priority pick.
package mux_onehot_pkg;

  localparam int MAXN  = 64;
  localparam int MAXCW = 6;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAXCW-1:0] oh2bin(
    input logic [MAXN-1:0] oh
  );
    logic [MAXCW-1:0] b;
    b = '0;
    for (int i = 0; i < MAXN; i++)
      if (oh[i[MAXCW-1:0]])
        b = b | i[MAXCW-1:0];
    return b;
  endfunction

  // Rotate req so ptr sits at bit 0, take the first set
  // bit, rotate the pick back into channel numbering.
  function automatic logic [MAXN-1:0] rr_first(
    input logic [MAXN-1:0] req,
    input int unsigned     ptr,
    input int unsigned     n
  );
    logic [MAXN-1:0] g;
    logic            hit;
    int unsigned     k;
    g   = '0;
    hit = 1'b0;
    for (int unsigned j = 0; j < MAXN; j++) begin
      k = ptr + j;
      if (k >= n)
        k = k - n;
      if (j < n && !hit && req[k[MAXCW-1:0]]) begin
        g[k[MAXCW-1:0]] = 1'b1;
        hit             = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux_onehot_rr_stage_arb.sv
// Combinational round-robin arbiter, one-hot grant.
// req/ptr in, grant out; lock_en/lock_idx with MUX_ONEHOT_RR_LOCK_EN.
module rr_onehot_arbiter
  import mux_onehot_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = cw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
`ifdef MUX_ONEHOT_RR_LOCK_EN
  input  logic          lock_en,
  input  logic [CW-1:0] lock_idx,
`endif
  output logic [N-1:0]  grant
);

  logic [N-1:0] w_rr;

  assign w_rr = N'(rr_first(MAXN'(req), 32'(ptr), N));

`ifdef MUX_ONEHOT_RR_LOCK_EN
  logic [N-1:0] w_lk;

  // A locked channel that drops valid gets no grant;
  // nobody else may slip in mid-packet.
  assign w_lk  = N'(MAXN'(1) << lock_idx) & req;
  assign grant = lock_en ? w_lk : w_rr;
`else
  assign grant = w_rr;
`endif

endmodule

// File: rtl/mux_onehot_rr_stage.sv
// N-channel round-robin one-hot mux into a 1-entry output register.
// Ports: clock, reset (async, low), io_in_* (valid/ready/data), io_out_*
// (valid/ready/data/sel/chan). MUX_ONEHOT_RR_LOCK_EN adds packet lock
// with io_in_last / io_out_last.
module mux_onehot_rr_stage
  import mux_onehot_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 32,
  localparam int CW = cw_of(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  output logic [N-1:0]   io_in_ready,
  input  logic [N*W-1:0] io_in_data,
`ifdef MUX_ONEHOT_RR_LOCK_EN
  input  logic [N-1:0]   io_in_last,
  output logic           io_out_last,
`endif
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_data,
  output logic [N-1:0]   io_out_sel,
  output logic [CW-1:0]  io_out_chan
);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [N-1:0]  r_sel;
  logic [CW-1:0] r_chan;
  logic [CW-1:0] r_ptr;

  logic          w_load;
  logic          w_fire;
  logic [N-1:0]  w_grant;
  logic [CW-1:0] w_chan;
  logic [CW-1:0] w_ptr_nxt;
  logic [W-1:0]  w_data;

`ifdef MUX_ONEHOT_RR_LOCK_EN
  logic r_lock;
  logic r_last;
  logic w_last;
`endif

  rr_onehot_arbiter #(.N(N)) u_arb (
    .req      (io_in_valid),
    .ptr      (r_ptr),
`ifdef MUX_ONEHOT_RR_LOCK_EN
    .lock_en  (r_lock),
    .lock_idx (r_chan),
`endif
    .grant    (w_grant)
  );

  assign w_load      = !r_valid || io_out_ready;
  assign io_in_ready = w_grant & {N{w_load}};
  assign w_fire      = w_load && (|w_grant);
  assign w_chan      = CW'(oh2bin(MAXN'(w_grant)));
  assign w_ptr_nxt   = (w_chan == CW'(N - 1))
                     ? '0 : w_chan + CW'(1);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++)
      w_data = w_data | (io_in_data[i*W +: W] & {W{w_grant[i]}});
  end

`ifdef MUX_ONEHOT_RR_LOCK_EN
  assign w_last = |(io_in_last & w_grant);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
`ifdef MUX_ONEHOT_RR_LOCK_EN
      r_lock  <= 1'b0;
      r_last  <= 1'b0;
`endif
    end else begin
      if (w_load)
        r_valid <= w_fire;
      if (w_fire) begin
        r_data <= w_data;
        r_sel  <= w_grant;
        r_chan <= w_chan;
`ifdef MUX_ONEHOT_RR_LOCK_EN
        // r_chan doubles as the lock index while locked.
        r_last <= w_last;
        r_lock <= !w_last;
        if (w_last)
          r_ptr <= w_ptr_nxt;
`else
        r_ptr  <= w_ptr_nxt;
`endif
      end
    end
  end

  assign io_out_valid = r_valid;
  assign io_out_data  = r_data;
  assign io_out_sel   = r_sel;
  assign io_out_chan  = r_chan;
`ifdef MUX_ONEHOT_RR_LOCK_EN
  assign io_out_last  = r_last;
`endif

endmodule

// File: tb/tb_mux_onehot_rr_stage.sv
// Bench for mux_onehot_rr_stage: directed vectors, a per-cycle
// reference model and literal checks. Honours MUX_ONEHOT_RR_LOCK_EN.
module tb_mux_onehot_rr_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   vin = '0;
  logic [3:0]   rdy;
  logic [31:0]  din [4];
  logic [127:0] din_p;
  logic         ordy = 1'b0;
  logic         ovld;
  logic [31:0]  odata;
  logic [3:0]   osel;
  logic [1:0]   ochan;

  logic         v1 = 1'b0;
  logic         r1;
  logic [7:0]   d1 = 8'h5A;
  logic         o1vld;
  logic [7:0]   o1data;
  logic         o1sel;
  logic         o1chan;

`ifdef MUX_ONEHOT_RR_LOCK_EN
  logic [3:0] lin = '0;
  logic       olast;
  logic       l1 = 1'b1;
  logic       o1last;
`endif

  assign din_p = {din[3], din[2], din[1], din[0]};

  mux_onehot_rr_stage #(.N(4), .W(32)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .io_in_valid  (vin),
    .io_in_ready  (rdy),
    .io_in_data   (din_p),
`ifdef MUX_ONEHOT_RR_LOCK_EN
    .io_in_last   (lin),
    .io_out_last  (olast),
`endif
    .io_out_valid (ovld),
    .io_out_ready (ordy),
    .io_out_data  (odata),
    .io_out_sel   (osel),
    .io_out_chan  (ochan)
  );

  mux_onehot_rr_stage #(.N(1), .W(8)) dut1 (
    .clock        (clk),
    .reset        (rst_n),
    .io_in_valid  (v1),
    .io_in_ready  (r1),
    .io_in_data   (d1),
`ifdef MUX_ONEHOT_RR_LOCK_EN
    .io_in_last   (l1),
    .io_out_last  (o1last),
`endif
    .io_out_valid (o1vld),
    .io_out_ready (1'b1),
    .io_out_data  (o1data),
    .io_out_sel   (o1sel),
    .io_out_chan  (o1chan)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: registered beat plus priority pointer.
  bit          m_valid, n_valid;
  logic [31:0] m_data,  n_data;
  logic [3:0]  m_sel,   n_sel;
  int          m_chan,  n_chan;
  int          m_ptr,   n_ptr;
`ifdef MUX_ONEHOT_RR_LOCK_EN
  bit          m_last,  n_last;
  bit          m_lock,  n_lock;
`endif

  function automatic int pick(input logic [3:0] v, input int p);
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (p + j) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int         g;
    bit         ld;
    logic [3:0] er;
    if (!rst_n) begin
      n_valid = 0; n_data = '0; n_sel = '0;
      n_chan = 0; n_ptr = 0;
`ifdef MUX_ONEHOT_RR_LOCK_EN
      n_last = 0; n_lock = 0;
`endif
    end else begin
      g = pick(vin, m_ptr);
`ifdef MUX_ONEHOT_RR_LOCK_EN
      if (m_lock) g = vin[m_chan] ? m_chan : -1;
`endif
      ld = !m_valid || ordy;
      er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
      chk("cmp_in_ready", rdy, er);
      chk("cmp_out_valid", ovld, m_valid);
      chk("cmp_out_data", odata, m_data);
      chk("cmp_out_sel", osel, m_sel);
      chk("cmp_out_chan", ochan, m_chan);
`ifdef MUX_ONEHOT_RR_LOCK_EN
      chk("cmp_out_last", olast, m_last);
`endif
      n_valid = m_valid; n_data = m_data; n_sel = m_sel;
      n_chan = m_chan; n_ptr = m_ptr;
`ifdef MUX_ONEHOT_RR_LOCK_EN
      n_last = m_last; n_lock = m_lock;
`endif
      if (ld) begin
        n_valid = 0;
        if (g >= 0) begin
          n_valid = 1;
          n_data  = din[g];
          n_sel   = 4'(1 << g);
          n_chan  = g;
`ifdef MUX_ONEHOT_RR_LOCK_EN
          n_last = lin[g];
          n_lock = !lin[g];
          if (lin[g]) n_ptr = (g + 1) % 4;
`else
          n_ptr = (g + 1) % 4;
`endif
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_data <= '0; m_sel <= '0;
      m_chan <= 0; m_ptr <= 0;
`ifdef MUX_ONEHOT_RR_LOCK_EN
      m_last <= 0; m_lock <= 0;
`endif
    end else begin
      m_valid <= n_valid; m_data <= n_data; m_sel <= n_sel;
      m_chan <= n_chan; m_ptr <= n_ptr;
`ifdef MUX_ONEHOT_RR_LOCK_EN
      m_last <= n_last; m_lock <= n_lock;
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 32'(32'hA0 + i);
`ifdef MUX_ONEHOT_RR_LOCK_EN
    lin = 4'b1111;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ovld, 0);
    chk("rst_data", odata, 0);
    chk("rst_sel", osel, 0);
    chk("rst_chan", ochan, 0);
    rst_n = 1'b1;

    // Test 1: all valid, consumer always ready.
    vin = 4'b1111; ordy = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_chan", ochan, 64'(k % 4));
      chk("t1_sel", osel, 64'(1) << (k % 4));
      chk("t1_data", odata, 64'(32'hA0 + k % 4));
      if (k == 0) begin
        chk("n1_valid", o1vld, 1);
        chk("n1_data", o1data, 8'h5A);
        chk("n1_sel", o1sel, 1);
        chk("n1_chan", o1chan, 0);
        v1 = 1'b0;
      end
      if (k == 1) begin
        chk("n1_idle", o1vld, 0);
        chk("n1_hold", o1data, 8'h5A);
      end
    end

    // Test 2: single channel under backpressure.
    vin = 4'b0100; din[2] = 32'hDEADBEEF;
    step();
    chk("t2_load", odata, 32'hDEADBEEF);
    ordy = 1'b0;
    #1;
    chk("t2_stall_rdy", rdy, 0);
    repeat (3) begin
      step();
      chk("t2_hold_v", ovld, 1);
      chk("t2_hold_d", odata, 32'hDEADBEEF);
      chk("t2_hold_c", ochan, 2);
      chk("t2_hold_rdy", rdy, 0);
    end
    ordy = 1'b1;
    #1;
    chk("t2_pass_rdy", rdy, 4'b0100);
    step();
    chk("t2_refill_v", ovld, 1);
    chk("t2_refill_c", ochan, 2);

    // Test 3: pointer at 3 wraps to channel 0.
    vin = 4'b0011; din[0] = 32'h11; din[1] = 32'h22;
    step();
    chk("t3_wrap_c", ochan, 0);
    chk("t3_wrap_d", odata, 32'h11);
    step();
    chk("t3_next_c", ochan, 1);
    chk("t3_next_d", odata, 32'h22);

    // Test 4: idle inputs; data held, pointer frozen at 2.
    vin = 4'b0000;
    repeat (5) begin
      step();
      chk("t4_idle_v", ovld, 0);
      chk("t4_idle_d", odata, 32'h22);
    end
    vin = 4'b1111;
    step();
    chk("t4_ptr_c", ochan, 2);

    // Test 5: async reset while a beat is held.
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_v", ovld, 0);
    chk("t5_async_s", osel, 0);
    chk("t5_async_d", odata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("t5_first_c", ochan, 0);
    chk("t5_first_d", odata, 32'h11);

`ifdef MUX_ONEHOT_RR_LOCK_EN
    // Test 6: ch1 packet of three beats holds the grant.
    vin = 4'b0111; lin = 4'b0101;
    step();
    chk("t6_b1_c", ochan, 1);
    chk("t6_b1_rdy", rdy, 4'b0010);
    step();
    chk("t6_b2_c", ochan, 1);
    chk("t6_b2_rdy", rdy, 4'b0010);
    lin = 4'b0111;
    step();
    chk("t6_b3_c", ochan, 1);
    chk("t6_b3_l", olast, 1);
    step();
    chk("t6_next_c", ochan, 2);
`endif

    vin = 4'b0000;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_onehot_rr_stage.md
Name: mux_onehot_rr_stage

Overview:
- Parametrised successor of the 4-to-1 one-hot mux: N channels of W-bit data.
- Each input channel has a valid/ready handshake.
- A round-robin arbiter produces a one-hot select; the data path is the one-hot AND-OR mux.
- The result lands in a one-entry registered output stage with valid/ready.
- Sits between multiple producers and a single downstream consumer in the datapath.

Parameters:
- N, 4, number of input channels (>=1)
- W, 32, data width per channel (>=1)
- CW, (N>1 ? $clog2(N) : 1), derived width of the channel index; not overridable

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- io_in_valid  input  N  per-channel valid; bit i belongs to channel i
- io_in_ready  output  N  per-channel ready; at most one bit set
- io_in_data  input  N*W  channel i occupies bits [i*W +: W]
- io_out_valid  output  1  output register holds a beat
- io_out_ready  input  1  consumer accepts the beat
- io_out_data  output  W  registered selected data
- io_out_sel  output  N  registered one-hot grant that produced io_out_data
- io_out_chan  output  CW  registered binary index of io_out_sel

Behaviour:
Reset:
- io_out_valid=0, io_out_data=0, io_out_sel=0, io_out_chan=0.
- Priority pointer ptr=0, so channel 0 has highest priority.

Load and grant:
- load = !io_out_valid | io_out_ready. This is combinational: io_out_ready passes through to io_in_ready.
- grant (one-hot, combinational) = first set bit of io_in_valid, searching from ptr upward with wrap-around. grant=0 if no valid.
- io_in_ready = grant & {N{load}}. A channel sees ready only if it is valid and granted.
- Transfer from channel k occurs when io_in_valid[k] & io_in_ready[k].

On a transfer (1 cycle latency):
- Next cycle io_out_valid=1.
- io_out_data = OR over i of (grant[i] ? data_i : 0).
- io_out_sel = grant; io_out_chan = k.
- ptr = (k+1) mod N.

No transfer with load=1:
- io_out_valid=0.
- io_out_data, io_out_sel and io_out_chan hold their previous values.
- ptr unchanged.

Backpressure and simultaneous events:
- Backpressure (io_out_valid=1, io_out_ready=0): all output registers are stable and io_in_ready=0.
- Simultaneous drain and fill (io_out_valid=1, io_out_ready=1, a valid input): the new beat replaces the old one in the same edge, with no bubble. Full throughput is 1 beat/cycle.

Boundary conditions:
- N=1: grant = io_in_valid[0]; ptr stays 0; io_out_chan=0.
- ptr wraps from N-1 to 0.
- All valids low: no grant, pointer frozen.
- Reset mid-operation: the pending output beat is discarded and the pointer returns to 0 immediately (async). Any beat shown before reset is lost.
- Inputs are not required to hold valid when not granted; the block imposes no stability checks.

Optional Feature:
- Macro MUX_ONEHOT_RR_LOCK_EN selects packet lock.
- Defined:
  - Adds port io_in_last (input, N), per-channel end-of-packet marker.
  - The block also carries an io_out_last register (reset 0), registered like data.
  - After a transfer from channel k with io_in_last[k]=0, the grant is locked to k. Other channels get ready=0 even if k drops valid.
  - The lock releases on the transfer with io_in_last[k]=1.
  - ptr advances to (k+1) mod N only on that last beat.
  - Reset clears the lock.
- Undefined:
  - No io_in_last/io_out_last ports.
  - Every beat is arbitrated independently as described above.

Decomposition:
- Package mux_onehot_pkg holds:
  - a function computing CW from N
  - a one-hot-to-binary encode function
  - the rotate-priority helper (rotate-left / find-first / rotate-back) used for grant generation
- Sub-module rr_onehot_arbiter(N):
  - inputs req[N], ptr[CW], and (with lock) lock_en and lock_idx
  - output grant[N] (one-hot)
  - purely combinational
- The parent owns ptr, the lock state, the output register and the AND-OR data mux.

Test Plan (N=4, W=32):
1. Reset, then io_in_valid=4'b1111, data i=32'hA0+i, io_out_ready=1 held → io_out_chan sequence 0,1,2,3,0, one per cycle from cycle 1; io_out_sel 0001,0010,0100,1000.
2. io_in_valid=4'b0100, data2=32'hDEADBEEF, io_out_ready=0 for 3 cycles → io_out_valid=1 with data DEADBEEF stable; io_in_ready=0 during the stall; release ready → one beat consumed, next beat loads the same edge.
3. ptr=3 after granting ch2, io_in_valid=4'b0011 → grant ch0 (wrap), then ch1.
4. All valids 0 for 5 cycles after a beat → io_out_valid drops to 0 after consumption; io_out_data holds the last value; ptr unchanged.
5. Assert reset (0) asynchronously mid-transfer with io_out_valid=1 → io_out_valid, io_out_sel and io_out_data go to 0 before the next edge; the first grant after release is ch0.
6. (MUX_ONEHOT_RR_LOCK_EN) ch1 sends 3 beats with last=0,0,1 while ch0 and ch2 are valid → io_out_chan=1,1,1, then 2; io_in_ready[0] and io_in_ready[2] stay 0 throughout the lock.
